// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Synchronises the serial line, validates the start bit, assembles a frame of
// DATA_BITS data bits (LSB first), an optional parity bit and 1 or 2 stop bits,
// then emits a single registered result pulse toward the rx FIFO.
module uart_rx_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 baud_tick,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 wr_en,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          ODD      = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // One-cycle result pulses, at most one set per frame.
  typedef struct packed {
    logic wr;
    logic ferr;
    logic perr;
    logic ovr;
  } result_t;

  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  result_t              res_q, res_d;

  logic full_hit;
  logic last_stop;

  assign full_hit  = baud_tick && (cnt_q == FULL_M1);
  // With two stop bits, stop_q marks that the first one has been sampled.
  assign last_stop = (STOP_BITS == 1) || stop_q;

  // Two-flop synchroniser on the raw line; idles high so reset does not look like a start bit.
  always_comb begin
    sync1_d = rx;
    rx_s_d  = sync1_q;
  end

  // Next-state, frame assembly and result decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    rx_data_d = rx_data_q;
    res_d     = '0;

    unique case (state_q)
      S_IDLE: begin
        // Falling edge on the line is enough; no tick needed to leave IDLE.
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end

      S_START: begin
        if (baud_tick) begin
          if (cnt_q == HALF_M1) begin
            // Mid start bit: still low means a real start, high means a glitch.
            cnt_d   = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DATA: begin
        if (full_hit) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT)
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else if (baud_tick) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PARITY: begin
        if (full_hit) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s_q) != ODD;
          state_d = S_STOP;
        end else if (baud_tick) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (full_hit) begin
          cnt_d  = '0;
          stop_d = 1'b1;
          if (!rx_s_q) ferr_d = 1'b1;
          if (last_stop) begin
            // A low final stop bit means the line may be in break; wait it out.
            state_d = rx_s_q ? S_IDLE : S_BREAK;
            // Priority: framing over parity over overrun; only a clean frame writes.
            if (ferr_q || !rx_s_q) begin
              res_d.ferr = 1'b1;
            end else if (perr_q) begin
              res_d.perr = 1'b1;
            end else if (fifo_full) begin
              res_d.ovr = 1'b1;
            end else begin
              res_d.wr  = 1'b1;
              rx_data_d = shift_q;
            end
          end
        end else if (baud_tick) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_data_q <= '0;
      res_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      rx_data_q <= rx_data_d;
      res_q     <= res_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign wr_en       = res_q.wr;
  assign frame_err   = res_q.ferr;
  assign parity_err  = res_q.perr;
  assign overrun_err = res_q.ovr;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: three configurations side by side
// (default 8N1, 8E1, 7N2), frames built bit by bit and outcomes predicted
// from frame contents.
module tb_uart_rx_frame_ctrl;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_full;
  logic       baud_tick;
  logic [2:0] rx;
  logic [2:0] wr, fe, pe, ov, busy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] dout [3];

  int db_of [3] = '{8, 8, 7};
  int pe_of [3] = '{0, 1, 0};
  int ns_of [3] = '{1, 1, 2};

  int tick_div = 1;
  int div_cnt  = 0;

  int cnt  [3][4];
  int snap [3][4];
  logic [8:0] exp_data [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) div_cnt <= (div_cnt >= tick_div - 1) ? 0 : div_cnt + 1;
  assign baud_tick = (div_cnt == 0);

  uart_rx_frame_ctrl u0 (
    .clk(clk), .reset(reset), .rx(rx[0]), .baud_tick(baud_tick), .fifo_full(fifo_full),
    .rx_data(d0), .wr_en(wr[0]), .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun_err(ov[0]), .busy(busy[0]));

  uart_rx_frame_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .rx(rx[1]), .baud_tick(baud_tick), .fifo_full(fifo_full),
    .rx_data(d1), .wr_en(wr[1]), .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun_err(ov[1]), .busy(busy[1]));

  uart_rx_frame_ctrl #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx(rx[2]), .baud_tick(baud_tick), .fifo_full(fifo_full),
    .rx_data(d2), .wr_en(wr[2]), .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun_err(ov[2]), .busy(busy[2]));

  assign dout[0] = {1'b0, d0};
  assign dout[1] = {1'b0, d1};
  assign dout[2] = {2'b00, d2};

  // Count pulse cycles per DUT, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr[i]) cnt[i][0] <= cnt[i][0] + 1;
      if (fe[i]) cnt[i][1] <= cnt[i][1] + 1;
      if (pe[i]) cnt[i][2] <= cnt[i][2] + 1;
      if (ov[i]) cnt[i][3] <= cnt[i][3] + 1;
    end
  end

  task automatic take_snap(input int id);
    for (int k = 0; k < 4; k++) snap[id][k] = cnt[id][k];
  endtask

  // {wr, frame, parity, overrun} pulse counts since the last snapshot.
  function automatic logic [15:0] deltas(input int id);
    return {4'(cnt[id][0] - snap[id][0]), 4'(cnt[id][1] - snap[id][1]),
            4'(cnt[id][2] - snap[id][2]), 4'(cnt[id][3] - snap[id][3])};
  endfunction

  // Expected outcome of one frame from its contents alone.
  function automatic logic [15:0] model(input int id, input logic [8:0] data,
                                        input logic pbit, input logic [1:0] stops,
                                        input logic ff);
    logic [8:0] mask;
    logic       fe_m, pe_m;
    mask = (9'h1 << db_of[id]) - 9'h1;
    fe_m = !stops[0] || (ns_of[id] == 2 && !stops[1]);
    pe_m = (pe_of[id] != 0) && ((^(data & mask)) ^ pbit);
    if (fe_m)      return 16'h0100;
    else if (pe_m) return 16'h0010;
    else if (ff)   return 16'h0001;
    else           return 16'h1000;
  endfunction

  task automatic drive_bit(input int id, input logic v, input int cycles);
    rx[id] = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input int id, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input logic final_rx,
                            input int idle_bits);
    int bl;
    bl = OS * tick_div;
    drive_bit(id, 1'b0, bl);
    for (int i = 0; i < db_of[id]; i++) drive_bit(id, data[i], bl);
    if (pe_of[id] != 0) drive_bit(id, pbit, bl);
    for (int s = 0; s < ns_of[id]; s++) drive_bit(id, stops[s], bl);
    rx[id] = final_rx;
    repeat (idle_bits * bl) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({wr[i], fe[i], pe[i], ov[i], busy[i]} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: got %b expected 00000", i,
                 {wr[i], fe[i], pe[i], ov[i], busy[i]});
      end
      vectors++;
      if (dout[i] !== 9'h0) begin
        miscompares++;
        $display("FAIL reset_rx_data dut%0d: got %h expected 000", i, dout[i]);
      end
    end
  endtask

  task automatic test_good();
    take_snap(0);
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1, 2);
    join_none
    repeat (3 * OS) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL good_busy_mid: got %b expected 1", busy[0]);
    end
    wait fork;
    exp_data[0] = 9'h0A5;
    vectors++;
    if (deltas(0) !== 16'h1000) begin
      miscompares++;
      $display("FAIL good_pulses: got %h expected 1000", deltas(0));
    end
    vectors++;
    if (dout[0] !== exp_data[0] || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL good_data_idle: got %h/%b expected %h/0", dout[0], busy[0], exp_data[0]);
    end
  endtask

  task automatic test_glitch();
    take_snap(0);
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy_seen: got %b expected 1", busy[0]);
    end
    rx[0] = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy_drop: got %b expected 0", busy[0]);
    end
    repeat (2 * OS) @(negedge clk);
    vectors++;
    if (deltas(0) !== 16'h0000) begin
      miscompares++;
      $display("FAIL glitch_pulses: got %h expected 0000", deltas(0));
    end
  endtask

  task automatic test_break();
    take_snap(0);
    send_frame(0, 9'h03C, 1'b0, 2'b00, 1'b0, 0);
    repeat (40) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL break_busy_hold: got %b expected 1", busy[0]);
    end
    rx[0] = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL break_busy_release: got %b expected 0", busy[0]);
    end
    vectors++;
    if (deltas(0) !== 16'h0100 || dout[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL break_pulses: got %h/%h expected 0100/%h", deltas(0), dout[0], exp_data[0]);
    end
    repeat (OS) @(negedge clk);
    take_snap(0);
    send_frame(0, 9'h055, 1'b0, 2'b11, 1'b1, 1);
    exp_data[0] = 9'h055;
    vectors++;
    if (deltas(0) !== 16'h1000 || dout[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL after_break_frame: got %h/%h expected 1000/%h", deltas(0), dout[0], exp_data[0]);
    end
    // Two stop bits, first low, second high: framing error without a break.
    take_snap(2);
    send_frame(2, 9'h02A, 1'b0, 2'b10, 1'b1, 1);
    vectors++;
    if (deltas(2) !== 16'h0100 || busy[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL stop2_first_low: got %h/%b expected 0100/0", deltas(2), busy[2]);
    end
  endtask

  task automatic test_parity();
    take_snap(1);
    send_frame(1, 9'h007, 1'b1, 2'b11, 1'b1, 1);
    exp_data[1] = 9'h007;
    vectors++;
    if (deltas(1) !== 16'h1000 || dout[1] !== exp_data[1]) begin
      miscompares++;
      $display("FAIL parity_good: got %h/%h expected 1000/%h", deltas(1), dout[1], exp_data[1]);
    end
    take_snap(1);
    send_frame(1, 9'h007, 1'b0, 2'b11, 1'b1, 1);
    vectors++;
    if (deltas(1) !== 16'h0010 || dout[1] !== exp_data[1]) begin
      miscompares++;
      $display("FAIL parity_bad: got %h/%h expected 0010/%h", deltas(1), dout[1], exp_data[1]);
    end
    take_snap(1);
    send_frame(1, 9'h007, 1'b0, 2'b00, 1'b1, 1);
    vectors++;
    if (deltas(1) !== 16'h0100) begin
      miscompares++;
      $display("FAIL parity_and_frame: got %h expected 0100", deltas(1));
    end
  endtask

  task automatic test_overrun();
    take_snap(0);
    fifo_full = 1'b1;
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b1, 1);
    fifo_full = 1'b0;
    vectors++;
    if (deltas(0) !== 16'h0001 || dout[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL overrun: got %h/%h expected 0001/%h", deltas(0), dout[0], exp_data[0]);
    end
    take_snap(0);
    send_frame(0, 9'h018, 1'b0, 2'b11, 1'b1, 1);
    exp_data[0] = 9'h018;
    vectors++;
    if (deltas(0) !== 16'h1000 || dout[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL after_overrun: got %h/%h expected 1000/%h", deltas(0), dout[0], exp_data[0]);
    end
  endtask

  task automatic test_reset_mid(input int id);
    int bl;
    bl = OS * tick_div;
    take_snap(id);
    drive_bit(id, 1'b0, bl);
    for (int i = 0; i < 4; i++) drive_bit(id, 1'b1, bl);
    repeat (bl / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_data[i] = 9'h0;
    repeat (2 * bl) @(negedge clk);
    vectors++;
    if (deltas(id) !== 16'h0000 || busy[id] !== 1'b0 || dout[id] !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_mid_abort dut%0d: got %h/%b/%h expected 0000/0/000", id,
               deltas(id), busy[id], dout[id]);
    end
    take_snap(id);
    send_frame(id, 9'h012, 1'b0, 2'b11, 1'b1, 1);
    exp_data[id] = 9'h012;
    vectors++;
    if (deltas(id) !== 16'h1000 || dout[id] !== exp_data[id]) begin
      miscompares++;
      $display("FAIL reset_mid_next dut%0d: got %h/%h expected 1000/%h", id,
               deltas(id), dout[id], exp_data[id]);
    end
  endtask

  // Random frames on random configurations, random tick rate, errors and
  // FIFO backpressure; idle gap may be zero for back-to-back reception.
  task automatic test_random();
    int         id, idle;
    logic [8:0] data, mask;
    logic       pbit, ff;
    logic [1:0] stops;
    logic [15:0] exp;
    for (int n = 0; n < 30; n++) begin
      id       = $urandom_range(0, 2);
      tick_div = $urandom_range(1, 3);
      data     = 9'($urandom);
      pbit     = 1'($urandom);
      stops    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      ff       = ($urandom_range(0, 3) == 0);
      idle     = $urandom_range(0, 2);
      if (stops != 2'b11 && idle == 0) idle = 1;
      mask     = (9'h1 << db_of[id]) - 9'h1;
      exp      = model(id, data, pbit, stops, ff);
      fifo_full = ff;
      take_snap(id);
      send_frame(id, data, pbit, stops, 1'b1, idle);
      if (exp == 16'h1000) exp_data[id] = data & mask;
      vectors++;
      if (deltas(id) !== exp) begin
        miscompares++;
        $display("FAIL random_pulses #%0d dut%0d data %h: got %h expected %h", n, id,
                 data, deltas(id), exp);
      end
      vectors++;
      if (dout[id] !== exp_data[id]) begin
        miscompares++;
        $display("FAIL random_data #%0d dut%0d: got %h expected %h", n, id,
                 dout[id], exp_data[id]);
      end
    end
    fifo_full = 1'b0;
    tick_div  = 1;
    repeat (OS) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) exp_data[i] = 9'h0;
    reset     = 1'b1;
    rx        = 3'b111;
    fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_good();
    test_glitch();
    test_break();
    test_parity();
    test_overrun();
    test_reset_mid(0);
    test_reset_mid(2);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
